// File: rtl/sata_rx_prim_decoder.sv
// SATA receive primitive decoder: classifies dwords as data or primitive, drops ALIGN, expands CONT.
// Optional ALIGN statistics counter is built when SATA_RX_ALIGN_STAT_EN is defined.
module sata_rx_prim_decoder #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              linkup,
  input  logic [31:0]       rx_datain,
  input  logic [3:0]        rx_charisk_in,
  output logic [31:0]       data_out,
  output logic              data_valid,
  output logic              prim_valid,
  output logic [4:0]        prim_code,
  output logic              prim_err,
  output logic              k_err,
  input  logic              align_clr,
  output logic [STAT_W-1:0] align_count
);

  typedef enum logic [4:0] {
    P_NONE    = 5'd0,  P_ALIGN   = 5'd1,  P_SYNC    = 5'd2,  P_CONT    = 5'd3,
    P_SOF     = 5'd4,  P_EOF     = 5'd5,  P_X_RDY   = 5'd6,  P_R_RDY   = 5'd7,
    P_R_IP    = 5'd8,  P_R_OK    = 5'd9,  P_R_ERR   = 5'd10, P_WTRM    = 5'd11,
    P_HOLD    = 5'd12, P_HOLDA   = 5'd13, P_DMAT    = 5'd14, P_PMREQ_P = 5'd15,
    P_PMREQ_S = 5'd16, P_PMACK   = 5'd17, P_PMNAK   = 5'd18
  } prim_e;

  typedef enum logic {ST_PASS, ST_HOLD} state_e;

  typedef struct packed {
    logic  is_data;
    logic  bad_k;
    prim_e code;
  } dec_t;

  dec_t   dec;
  state_e state;
  prim_e  last_prim;

  // Only a single K28.x in byte0 forms a legal primitive; anything else is a charisk error.
  always_comb begin
    dec         = '0;
    dec.code    = P_NONE;
    dec.is_data = (rx_charisk_in == 4'b0000);
    dec.bad_k   = 1'b0;
    if (!dec.is_data) begin
      if (rx_charisk_in != 4'b0001 ||
          (rx_datain[7:0] != 8'hBC && rx_datain[7:0] != 8'h7C)) begin
        dec.bad_k = 1'b1;
      end else begin
        case (rx_datain)
          32'h7B4A4ABC: dec.code = P_ALIGN;
          32'hB5B5957C: dec.code = P_SYNC;
          32'h9999AA7C: dec.code = P_CONT;
          32'h3737B57C: dec.code = P_SOF;
          32'hD5D5B57C: dec.code = P_EOF;
          32'h5757B57C: dec.code = P_X_RDY;
          32'h4A4A957C: dec.code = P_R_RDY;
          32'h5555B57C: dec.code = P_R_IP;
          32'h3535B57C: dec.code = P_R_OK;
          32'h5656B57C: dec.code = P_R_ERR;
          32'h5858B57C: dec.code = P_WTRM;
          32'hD5D5AA7C: dec.code = P_HOLD;
          32'h9595AA7C: dec.code = P_HOLDA;
          32'h3636B57C: dec.code = P_DMAT;
          32'h1717B57C: dec.code = P_PMREQ_P;
          32'h7575957C: dec.code = P_PMREQ_S;
          32'h9595957C: dec.code = P_PMACK;
          32'hF5F5957C: dec.code = P_PMNAK;
          default:      dec.code = P_NONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_PASS;
      last_prim  <= P_NONE;
      data_out   <= '0;
      data_valid <= 1'b0;
      prim_valid <= 1'b0;
      prim_code  <= '0;
      prim_err   <= 1'b0;
      k_err      <= 1'b0;
    end else begin
      data_out   <= '0;
      data_valid <= 1'b0;
      prim_valid <= 1'b0;
      prim_code  <= '0;
      prim_err   <= 1'b0;
      k_err      <= 1'b0;
      if (!linkup) begin
        state     <= ST_PASS;
        last_prim <= P_NONE;
      end else if (dec.is_data) begin
        // While a CONT run is active, data-coded dwords are scrambler junk.
        if (state == ST_PASS) begin
          data_valid <= 1'b1;
          data_out   <= rx_datain;
        end else begin
          prim_valid <= 1'b1;
          prim_code  <= last_prim;
        end
      end else if (dec.bad_k) begin
        k_err <= 1'b1;
      end else begin
        case (dec.code)
          P_NONE:  prim_err <= 1'b1;
          P_ALIGN: ;
          P_CONT: begin
            if (last_prim == P_NONE) begin
              prim_err <= 1'b1;
            end else begin
              prim_valid <= 1'b1;
              prim_code  <= last_prim;
              state      <= ST_HOLD;
            end
          end
          default: begin
            prim_valid <= 1'b1;
            prim_code  <= dec.code;
            last_prim  <= dec.code;
            state      <= ST_PASS;
          end
        endcase
      end
    end
  end

`ifdef SATA_RX_ALIGN_STAT_EN
  logic [STAT_W-1:0] align_cnt_q;
  logic              align_hit;

  assign align_hit = linkup && !dec.is_data && !dec.bad_k && (dec.code == P_ALIGN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          align_cnt_q <= '0;
    else if (align_clr)                    align_cnt_q <= '0;
    else if (align_hit && ~&align_cnt_q)   align_cnt_q <= align_cnt_q + 1'b1;
  end

  assign align_count = align_cnt_q;
`else
  logic unused_align_clr;
  assign unused_align_clr = align_clr;
  assign align_count      = '0;
`endif

endmodule

// File: tb/tb_sata_rx_prim_decoder.sv
// Scoreboard bench for sata_rx_prim_decoder: driver queues expected outputs, monitor compares one cycle later.
module tb_sata_rx_prim_decoder;
  localparam int STAT_W = 4;
`ifdef SATA_RX_ALIGN_STAT_EN
  localparam logic [STAT_W-1:0] EXP_SAT = 4'd15;
`else
  localparam logic [STAT_W-1:0] EXP_SAT = 4'd0;
`endif

  localparam logic [31:0] ALIGN = 32'h7B4A4ABC, SYNC = 32'hB5B5957C, CONT = 32'h9999AA7C,
                          SOF   = 32'h3737B57C, XRDY = 32'h5757B57C, RRDY = 32'h4A4A957C,
                          HOLD  = 32'hD5D5AA7C;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              linkup;
  logic [31:0]       rx_datain;
  logic [3:0]        rx_charisk_in;
  logic [31:0]       data_out;
  logic              data_valid;
  logic              prim_valid;
  logic [4:0]        prim_code;
  logic              prim_err;
  logic              k_err;
  logic              align_clr;
  logic [STAT_W-1:0] align_count;

  sata_rx_prim_decoder #(.STAT_W(STAT_W)) dut (
    .clk(clk), .reset_n(reset_n), .linkup(linkup), .rx_datain(rx_datain),
    .rx_charisk_in(rx_charisk_in), .data_out(data_out), .data_valid(data_valid),
    .prim_valid(prim_valid), .prim_code(prim_code), .prim_err(prim_err), .k_err(k_err),
    .align_clr(align_clr), .align_count(align_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [31:0] d;
    logic        pv;
    logic [4:0]  c;
    logic        pe;
    logic        ke;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic clr_nxt = 1'b0;
  logic [31:0] ptab [0:18];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each expectation is compared on the cycle after it was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (reset_n && q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        if (data_valid !== e.dv || data_out !== e.d || prim_valid !== e.pv ||
            prim_code !== e.c || prim_err !== e.pe || k_err !== e.ke) begin
          errors++;
          $display("FAIL out@%0d got dv=%b d=%h pv=%b c=%0d pe=%b ke=%b want dv=%b d=%h pv=%b c=%0d pe=%b ke=%b",
                   cyc, data_valid, data_out, prim_valid, prim_code, prim_err, k_err,
                   e.dv, e.d, e.pv, e.c, e.pe, e.ke);
        end
      end
    end
  end

  task automatic send(input logic lu, input logic [3:0] k, input logic [31:0] d,
                      input logic dv, input logic pv, input logic [4:0] c,
                      input logic pe, input logic ke);
    exp_t e;
    @(posedge clk);
    #1;
    linkup        = lu;
    rx_charisk_in = k;
    rx_datain     = d;
    align_clr     = clr_nxt;
    e.dv = dv; e.d = dv ? d : 32'h0; e.pv = pv; e.c = c; e.pe = pe; e.ke = ke; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic prim(input logic [31:0] d, input logic [4:0] c);
    send(1'b1, 4'b0001, d, 1'b0, 1'b1, c, 1'b0, 1'b0);
  endtask
  task automatic dat(input logic [31:0] d);
    send(1'b1, 4'b0000, d, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic junk(input logic [31:0] d, input logic [4:0] c);
    send(1'b1, 4'b0000, d, 1'b0, 1'b1, c, 1'b0, 1'b0);
  endtask
  task automatic quiet(input logic lu, input logic [3:0] k, input logic [31:0] d);
    send(lu, k, d, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic err(input logic [3:0] k, input logic [31:0] d, input logic pe, input logic ke);
    send(1'b1, k, d, 1'b0, 1'b0, 5'd0, pe, ke);
  endtask

  task automatic chk_idle(input string name);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 32'h0 || prim_valid !== 1'b0 ||
        prim_code !== 5'd0 || prim_err !== 1'b0 || k_err !== 1'b0) begin
      errors++;
      $display("FAIL %s got dv=%b d=%h pv=%b c=%0d pe=%b ke=%b want all zero",
               name, data_valid, data_out, prim_valid, prim_code, prim_err, k_err);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [STAT_W-1:0] want);
    checks++;
    if (align_count !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, align_count, want);
    end
  endtask

  initial begin
    int wait_cyc;
    ptab = '{32'h0, ALIGN, SYNC, CONT, SOF, 32'hD5D5B57C, XRDY, RRDY, 32'h5555B57C,
             32'h3535B57C, 32'h5656B57C, 32'h5858B57C, HOLD, 32'h9595AA7C, 32'h3636B57C,
             32'h1717B57C, 32'h7575957C, 32'h9595957C, 32'hF5F5957C};
    reset_n = 1'b0; linkup = 1'b0; rx_datain = '0; rx_charisk_in = '0; align_clr = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk_idle("reset_state");
    chk_cnt("reset_count", '0);
    @(negedge clk) reset_n = 1'b1;

    // linkup low: input ignored
    quiet(1'b0, 4'b0000, 32'hDEADBEEF);
    quiet(1'b0, 4'b0001, XRDY);

    // basic primitives then data
    prim(XRDY, 5'd6); prim(XRDY, 5'd6); prim(SOF, 5'd4); dat(32'h12345678);

    // CONT expansion with junk and an ALIGN inside the run
    prim(XRDY, 5'd6); prim(CONT, 5'd6);
    repeat (3) junk(32'hA5A5A5A5, 5'd6);
    quiet(1'b1, 4'b0001, ALIGN);
    junk(32'hA5A5A5A5, 5'd6);
    prim(SOF, 5'd4); dat(32'h0BADF00D);

    // errors: CONT with no prior primitive, illegal charisk, unknown K
    quiet(1'b0, 4'b0000, 32'h0);
    err(4'b0001, CONT, 1'b1, 1'b0);
    err(4'b0010, 32'h11223344, 1'b0, 1'b1);
    err(4'b1111, 32'hBCBCBCBC, 1'b0, 1'b1);
    err(4'b0001, 32'h1234567C, 1'b1, 1'b0);
    dat(32'h0000FFFF);

    // errors inside HOLD keep the run and last_prim
    prim(SYNC, 5'd2); prim(CONT, 5'd2);
    err(4'b0010, 32'h55667788, 1'b0, 1'b1);
    junk(32'h13579BDF, 5'd2);
    err(4'b0001, 32'h1234567C, 1'b1, 1'b0);
    quiet(1'b1, 4'b0001, ALIGN);
    junk(32'h2468ACE0, 5'd2);
    prim(HOLD, 5'd12); dat(32'hFEEDFACE);

    // linkup drop mid-CONT clears last_prim
    prim(RRDY, 5'd7); prim(CONT, 5'd7); junk(32'h77777777, 5'd7);
    quiet(1'b0, 4'b0000, 32'h77777777);
    dat(32'h87654321);
    err(4'b0001, CONT, 1'b1, 1'b0);

    // full primitive table
    for (int i = 2; i <= 18; i++) if (i != 3) prim(ptab[i], 5'(i));

    // ALIGN statistics: saturation then clear
    repeat (20) quiet(1'b1, 4'b0001, ALIGN);
    @(posedge clk); #3;
    chk_cnt("align_sat", EXP_SAT);
    clr_nxt = 1'b1;
    quiet(1'b1, 4'b0001, ALIGN);
    clr_nxt = 1'b0;
    @(posedge clk); #3;
    chk_cnt("align_clr", '0);

    // async reset mid-stream
    dat(32'hCAFEF00D);
    @(posedge clk); #3;
    reset_n = 1'b0;
    q.delete();
    #1;
    chk_idle("async_reset");
    @(negedge clk) reset_n = 1'b1;
    quiet(1'b0, 4'b0000, 32'h99999999);
    quiet(1'b0, 4'b0001, SOF);
    dat(32'h0F0F0F0F);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
